// File: rtl/daq_rx_frame_chk.sv
// DAQ receive frame checker: parses the 16-bit + K-flag word stream from the
// GTX receiver into event frames. Checks framing, payload length and CRC-16,
// and optionally the L1A sequence. Emits per-frame status strobes, event/error
// counters and the last L1A number.
// Optional feature macro: DAQ_RX_SEQ_CHK_EN enables the header L1A sequence
// check. When it is undefined, SEQ_ERR is tied low.
module daq_rx_frame_chk #(
  parameter int          PAYLOAD_WORDS = 97,
  parameter logic [15:0] SOF_WORD      = 16'hF7FB,
  parameter logic [15:0] EOF_WORD      = 16'hFDFE,
  parameter logic [15:0] IDLE_WORD     = 16'h50BC
) (
  input  logic        DAQ_RX_CLK,
  input  logic        SYS_RST,
  input  logic        RX_VLD,
  input  logic [15:0] RX_DATA,
  input  logic [1:0]  RX_K,
  output logic [15:0] PAY_DATA,
  output logic        PAY_VLD,
  output logic        FRAME_DONE,
  output logic        FRAME_OK,
  output logic        CRC_ERR,
  output logic        LEN_ERR,
  output logic        SEQ_ERR,
  output logic [15:0] EVT_CNT,
  output logic [15:0] ERR_CNT,
  output logic [11:0] LAST_L1A
);

  localparam int             CW       = $clog2(PAYLOAD_WORDS + 1);
  localparam logic [CW-1:0]  LAST_IDX = CW'(PAYLOAD_WORDS - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_PAYLOAD, ST_CRCW, ST_EOFW} state_t;
  typedef enum logic [2:0] {W_SOF, W_EOF, W_IDLE, W_DATA, W_BADK} wclass_t;

  state_t          state, state_nxt;
  wclass_t         wclass;
  logic [CW-1:0]   word_cnt;
  logic [15:0]     crc;
  logic [15:0]     crc_nxt;
  logic [11:0]     l1a_cap;
  logic            hdr_seen;
  logic            crc_bad;
  logic            seq_bad_now;

  // Control decoded from the current word
  logic            frame_end;
  logic            len_err_now;
  logic            start_frame;
  logic            pay_accept;
  logic            crc_check;
  logic            frame_ok_now;

  // CRC-16-CCITT (poly 0x1021), MSB first, one full 16-bit word per call
  function automatic logic [15:0] crc16_upd(input logic [15:0] c, input logic [15:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 15; i >= 0; i--) begin
      r = {r[14:0], 1'b0} ^ ((r[15] ^ d[i]) ? 16'h1021 : 16'h0000);
    end
    return r;
  endfunction

  assign crc_nxt = crc16_upd(crc, RX_DATA);

  // Classify the incoming word by K flags and value
  always_comb begin
    wclass = W_BADK;
    if (RX_K == 2'b11 && RX_DATA == SOF_WORD)       wclass = W_SOF;
    else if (RX_K == 2'b11 && RX_DATA == EOF_WORD)  wclass = W_EOF;
    else if (RX_K == 2'b01 && RX_DATA == IDLE_WORD) wclass = W_IDLE;
    else if (RX_K == 2'b00)                         wclass = W_DATA;
  end

  // State register
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge DAQ_RX_CLK or posedge SYS_RST) begin
    if (SYS_RST) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // Next-state and per-word control decode; RX_VLD low holds everything
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_nxt   = state;
    frame_end   = 1'b0;
    len_err_now = 1'b0;
    start_frame = 1'b0;
    pay_accept  = 1'b0;
    crc_check   = 1'b0;
    if (RX_VLD) begin
      case (state)
        ST_IDLE: begin
          if (wclass == W_SOF) begin
            state_nxt   = ST_PAYLOAD;
            start_frame = 1'b1;
          end
        end
        ST_PAYLOAD: begin
          case (wclass)
            W_DATA: begin
              pay_accept = 1'b1;
              if (word_cnt == LAST_IDX) state_nxt = ST_CRCW;
            end
            W_IDLE: ;
            W_SOF: begin
              frame_end   = 1'b1;
              len_err_now = 1'b1;
              start_frame = 1'b1;
            end
            default: begin
              frame_end   = 1'b1;
              len_err_now = 1'b1;
              state_nxt   = ST_IDLE;
            end
          endcase
        end
        ST_CRCW: begin
          case (wclass)
            W_DATA: begin
              crc_check = 1'b1;
              state_nxt = ST_EOFW;
            end
            W_IDLE: ;
            W_SOF: begin
              frame_end   = 1'b1;
              len_err_now = 1'b1;
              start_frame = 1'b1;
              state_nxt   = ST_PAYLOAD;
            end
            default: begin
              frame_end   = 1'b1;
              len_err_now = 1'b1;
              state_nxt   = ST_IDLE;
            end
          endcase
        end
        ST_EOFW: begin
          case (wclass)
            W_EOF: begin
              frame_end = 1'b1;
              state_nxt = ST_IDLE;
            end
            W_IDLE: ;
            W_SOF: begin
              frame_end   = 1'b1;
              len_err_now = 1'b1;
              start_frame = 1'b1;
              state_nxt   = ST_PAYLOAD;
            end
            default: begin
              frame_end   = 1'b1;
              len_err_now = 1'b1;
              state_nxt   = ST_IDLE;
            end
          endcase
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // crc_bad can only be set by a received CRC word, so it already implies "CRC seen"
  assign frame_ok_now = ~(len_err_now | crc_bad | seq_bad_now);

`ifdef DAQ_RX_SEQ_CHK_EN
  logic [11:0] l1a_exp;
  logic        first_frm;
  logic        seq_bad;

  assign seq_bad_now = seq_bad;

  // L1A sequence tracking: expected value reloads from every header
  always_ff @(posedge DAQ_RX_CLK or posedge SYS_RST) begin
    if (SYS_RST) begin
      l1a_exp   <= 12'd0;
      first_frm <= 1'b1;
      seq_bad   <= 1'b0;
      SEQ_ERR   <= 1'b0;
    end else begin
      SEQ_ERR <= frame_end & seq_bad;
      if (start_frame) begin
        seq_bad <= 1'b0;
      end else if (pay_accept && word_cnt == '0) begin
        seq_bad   <= ~first_frm && (RX_DATA[11:0] != l1a_exp);
        l1a_exp   <= RX_DATA[11:0] + 12'd1;
        first_frm <= 1'b0;
      end
    end
  end
`else
  assign seq_bad_now = 1'b0;
  assign SEQ_ERR     = 1'b0;
`endif

  // Frame datapath: payload forwarding, CRC, header capture, status and counters
  always_ff @(posedge DAQ_RX_CLK or posedge SYS_RST) begin
    if (SYS_RST) begin
      word_cnt   <= '0;
      crc        <= 16'hFFFF;
      l1a_cap    <= 12'd0;
      hdr_seen   <= 1'b0;
      crc_bad    <= 1'b0;
      PAY_DATA   <= 16'd0;
      PAY_VLD    <= 1'b0;
      FRAME_DONE <= 1'b0;
      FRAME_OK   <= 1'b0;
      CRC_ERR    <= 1'b0;
      LEN_ERR    <= 1'b0;
      EVT_CNT    <= 16'd0;
      ERR_CNT    <= 16'd0;
      LAST_L1A   <= 12'd0;
    end else begin
      PAY_VLD    <= 1'b0;
      FRAME_DONE <= frame_end;
      FRAME_OK   <= frame_end & frame_ok_now;
      CRC_ERR    <= frame_end & crc_bad;
      LEN_ERR    <= frame_end & len_err_now;

      if (pay_accept) begin
        PAY_DATA <= RX_DATA;
        PAY_VLD  <= 1'b1;
        crc      <= crc_nxt;
        word_cnt <= word_cnt + CW'(1);
        if (word_cnt == '0) begin
          l1a_cap  <= RX_DATA[11:0];
          hdr_seen <= 1'b1;
        end
      end

      if (crc_check) crc_bad <= (RX_DATA != crc);

      if (frame_end) begin
        if (hdr_seen) LAST_L1A <= l1a_cap;
        if (frame_ok_now) begin
          if (EVT_CNT != 16'hFFFF) EVT_CNT <= EVT_CNT + 16'd1;
        end else begin
          if (ERR_CNT != 16'hFFFF) ERR_CNT <= ERR_CNT + 16'd1;
        end
      end

      // A restart clears per-frame state after the ending frame was reported
      if (start_frame) begin
        word_cnt <= '0;
        crc      <= 16'hFFFF;
        hdr_seen <= 1'b0;
        crc_bad  <= 1'b0;
      end
    end
  end

endmodule
